subn_serial: RTL and testbench
==============================

Name: subn_serial

Overview:
- Bit-serial n-bit two's-complement subtractor: computes diff = a - b - bi over n clock cycles, one bit per cycle, LSB first.
- It is the inverse-direction counterpart of the team's parallel ripple adder. It provides the same carry/overflow contract, expressed as borrow, at one full-subtractor cell of area.
- Sits beside the ALU datapath. It is used where a slow, small subtract path is acceptable, e.g. compare/decrement in control units.

Parameters:
- n, 8, operand/result width in bits; legal range n >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when ready=1.
- a  input  n  minuend; captured on the accepting edge.
- b  input  n  subtrahend; captured on the accepting edge.
- bi  input  1  borrow-in; captured on the accepting edge.
- ready  output  1  block idle and able to accept start.
- done  output  1  single-cycle pulse: diff/bo/overflow just became valid.
- diff  output  n  result a - b - bi (mod 2^n).
- bo  output  1  borrow-out of the MSB (1 = unsigned underflow).
- overflow  output  1  signed overflow = (borrow into MSB) XOR bo.

Behaviour:
- Clock and reset:
  - One clock (clk).
  - Reset is asynchronous and active-low (rst_n). It takes effect immediately and is released synchronously to clk by the system.
- Reset values: ready=1, done=0, diff=0, bo=0, overflow=0. FSM is in IDLE, bit counter=0, internal shift registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On an edge with start=1: capture a, b into shift registers and bi into the borrow flop, clear the counter, go to RUN.
  - start=0: stay.
- RUN:
  - ready=0.
  - Each edge processes bit i = counter, using one full-subtractor cell:
    - d = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d is shifted into the MSB of the result shift register; operand registers shift right by 1; counter increments.
  - On the edge processing bit n-1:
    - capture the borrow into the MSB (br before update) as br_msb_in;
    - load diff from the completed result register, bo = br_next, overflow = br_msb_in ^ br_next;
    - go to DONE.
- DONE:
  - done=1, ready=0 for exactly one cycle.
  - The next edge returns to IDLE unconditionally.
- Latency:
  - Start is accepted at edge T0.
  - done is high in the cycle following edge Tn, i.e. n cycles after the accepting edge.
  - ready returns high one cycle later.
  - Throughput is one operation per n+2 cycles.
- Output stability:
  - diff, bo and overflow change only on the edge entering DONE.
  - They hold their values through IDLE until the next operation completes; intermediate serial results are never visible on the outputs.
- start while ready=0 (RUN or DONE) is ignored; no queuing.
- a, b and bi may change freely after the accepting edge.
- Counter width is $clog2(n). Wrap-around never occurs, because the counter is cleared on accept and RUN exits at n-1.
- Reset asserted mid-RUN or in DONE: the operation is aborted, all state returns to reset values, and no done pulse is produced.
- Width rules:
  - all arithmetic is modulo 2^n;
  - bo=1 iff unsigned a < b + bi;
  - overflow=1 iff the signed result is not representable in n bits.

Decomposition:
- Shared package: FSM state encoding constants (IDLE, RUN, DONE) and the borrow/overflow definition comment, so the parallel and serial arithmetic blocks use one source.
- One sub-module is natural: subtractor, a 1-bit combinational full-subtractor cell. Ports: a, b, bi inputs; d, bo outputs. It mirrors the team's 1-bit adder cell and is instantiated once inside subn_serial.

Test Plan:
- Reset mid-RUN: n=8, start 0x05 - 0x03, assert rst_n=0 at cycle 4. Required: outputs immediately 0, ready=1, no done pulse. After release, a new start of 0x05 - 0x03, bi=0, yields diff=0x02, bo=0, overflow=0, with done exactly 8 cycles after the accept edge.
- Unsigned underflow: 0x00 - 0x01, bi=0 -> diff=0xFF, bo=1, overflow=0.
- Signed overflow (negative to positive): 0x80 - 0x01, bi=0 -> diff=0x7F, bo=0, overflow=1.
- Signed overflow (positive to negative) with borrow-out: 0x7F - 0xFF, bi=0 -> diff=0x80, bo=1, overflow=1.
- Borrow-in path: 0x10 - 0x10, bi=1 -> diff=0xFF, bo=1, overflow=0.
- Protocol:
  - Hold start=1 continuously with changing a/b. Accepts occur only when ready=1, giving one result per 10 cycles.
  - Operand changes after accept do not alter the result.
  - diff stays stable between done pulses.
  - n=2 instance: 0b10 - 0b01 -> diff=0b01, bo=0, overflow=1.

Source files
------------

// File: rtl/subn_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module  : subn_serial_pkg
// Purpose : Shared FSM encoding and borrow/overflow definitions for the
//           serial subtractor and its full-subtractor cell.
// Rev     : 1.0 - initial release
// ============================================================================
package subn_serial_pkg;

    // Borrow-out (bo) of the MSB flags unsigned underflow (a < b + bi).
    // Signed overflow is the XOR of the borrow into the MSB with bo.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/subn_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : subn_serial_subtractor
// Purpose : 1-bit combinational full-subtractor cell (d = a - b - bi).
// Rev     : 1.0 - initial release
// ============================================================================
module subn_serial_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign d     = w_axb ^ bi;
    assign bo    = (~a & b) | (~w_axb & bi);

endmodule
`default_nettype wire

// File: rtl/subn_serial.sv
`default_nettype none
// ============================================================================
// Module  : subn_serial
// Purpose : Bit-serial N-bit two's-complement subtractor, LSB first,
//           one full-subtractor cell, result valid N cycles after accept.
// Rev     : 1.0 - initial release
// ============================================================================
module subn_serial
    import subn_serial_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bi,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bo,
    output logic         overflow
);

    localparam int             CNT_W  = $clog2(N);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_res;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_diff;
    logic             r_bo;
    logic             r_ovf;

    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic [N-1:0]     w_res_next;

    subn_serial_subtractor u_cell (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .bi (r_br),
        .d  (w_d),
        .bo (w_br_next)
    );

    assign w_last     = (r_cnt == C_LAST);
    assign w_res_next = {w_d, r_res[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are loaded only on the final bit so partial results stay hidden.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bo   <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_br  <= bi;
                        r_res <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_res <= w_res_next;
                    r_a   <= {1'b0, r_a[N-1:1]};
                    r_b   <= {1'b0, r_b[N-1:1]};
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_diff <= w_res_next;
                        r_bo   <= w_br_next;
                        r_ovf  <= r_br ^ w_br_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff     = r_diff;
    assign bo       = r_bo;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_subn_serial.sv
`default_nettype none
// ============================================================================
// Module  : tb_subn_serial
// Purpose : Scoreboard bench for subn_serial (N=8 and N=2 instances).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_subn_serial;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    int         cyc;
    int         n_checks;
    int         n_errors;

    logic       start8, bi8;
    logic [7:0] a8, b8;
    logic       ready8, done8, bo8, ovf8;
    logic [7:0] diff8;

    logic       start2, bi2;
    logic [1:0] a2, b2;
    logic       ready2, done2, bo2, ovf2;
    logic [1:0] diff2;

    exp_t       q8[$];
    exp_t       q2[$];
    logic [9:0] hold8;
    logic [3:0] hold2;

    subn_serial #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bi(bi8),
        .ready(ready8), .done(done8), .diff(diff8), .bo(bo8), .overflow(ovf8)
    );

    subn_serial #(.N(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bi(bi2),
        .ready(ready2), .done(done2), .diff(diff2), .bo(bo2), .overflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t ref_sub8(input logic [7:0] x, input logic [7:0] y,
                                      input logic c, input int when);
        exp_t       e;
        logic [8:0] w;
        w     = {1'b0, x} - {1'b0, y} - {8'd0, c};
        e.d   = w[7:0];
        e.bo  = w[8];
        e.ovf = (x[7] != y[7]) && (w[7] != x[7]);
        e.cyc = when;
        return e;
    endfunction

    // Monitor: pops expectations on done, checks hold stability otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold8 = '0;
            hold2 = '0;
        end else begin
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("dut8_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q8.pop_front();
                    chk("dut8_diff", {24'd0, diff8}, {24'd0, e.d});
                    chk("dut8_bo", {31'd0, bo8}, {31'd0, e.bo});
                    chk("dut8_ovf", {31'd0, ovf8}, {31'd0, e.ovf});
                    chk("dut8_done_cycle", cyc, e.cyc);
                end
                hold8 = {diff8, bo8, ovf8};
            end else begin
                chk("dut8_hold", {22'd0, diff8, bo8, ovf8}, {22'd0, hold8});
            end
            if (done2) begin
                if (q2.size() == 0) begin
                    chk("dut2_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q2.pop_front();
                    chk("dut2_diff", {30'd0, diff2}, {24'd0, e.d});
                    chk("dut2_bo", {31'd0, bo2}, {31'd0, e.bo});
                    chk("dut2_ovf", {31'd0, ovf2}, {31'd0, e.ovf});
                    chk("dut2_done_cycle", cyc, e.cyc);
                end
                hold2 = {diff2, bo2, ovf2};
            end else begin
                chk("dut2_hold", {28'd0, diff2, bo2, ovf2}, {28'd0, hold2});
            end
        end
    end

    task automatic wait_ready8(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ready8) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("dut8_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbi,
                       input logic [7:0] ed, input logic eb, input logic eo);
        bit   ok;
        exp_t e;
        wait_ready8(ok);
        if (!ok) return;
        a8 = ta; b8 = tb; bi8 = tbi; start8 = 1'b1;
        @(negedge clk);
        chk("dut8_accepted", {31'd0, ready8}, 32'd0);
        e.d = ed; e.bo = eb; e.ovf = eo; e.cyc = cyc + 8;
        q8.push_back(e);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
    endtask

    initial begin
        bit   ok;
        int   last_acc;
        exp_t e;
        n_checks = 0; n_errors = 0;
        hold8 = '0; hold2 = '0;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; bi2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready8}, 32'd1);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_outputs", {22'd0, diff8, bo8, ovf8}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned underflow; leaves non-zero outputs ahead of the reset test.
        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);

        // Abort an operation mid-RUN with reset.
        wait_ready8(ok);
        a8 = 8'h05; b8 = 8'h03; bi8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, ready8}, 32'd1);
        chk("abort_done", {31'd0, done8}, 32'd0);
        chk("abort_outputs", {22'd0, diff8, bo8, ovf8}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

        op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        op8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        op8(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);

        // start held high with operands changing every cycle.
        last_acc = -1;
        for (int i = 0; i < 36; i++) begin
            a8 = 8'(i * 37 + 11); b8 = 8'(i * 91 + 200); bi8 = 1'(i % 3 == 0);
            start8 = 1'b1;
            if (ready8) begin
                e = ref_sub8(a8, b8, bi8, cyc + 1 + 8);
                q8.push_back(e);
                if (last_acc >= 0) chk("accept_spacing", cyc + 1 - last_acc, 32'd10);
                last_acc = cyc + 1;
            end
            @(negedge clk);
        end
        start8 = 1'b0;

        // N=2 instance.
        for (int i = 0; i < 20 && !ready2; i++) @(negedge clk);
        a2 = 2'b10; b2 = 2'b01; bi2 = 1'b0; start2 = 1'b1;
        @(negedge clk);
        chk("dut2_accepted", {31'd0, ready2}, 32'd0);
        e.d = 8'h01; e.bo = 1'b0; e.ovf = 1'b1; e.cyc = cyc + 2;
        q2.push_back(e);
        start2 = 1'b0; a2 = 2'b11; b2 = 2'b11; bi2 = 1'b1;

        for (int i = 0; i < 40 && (q8.size() != 0 || q2.size() != 0); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("drain_dut8", q8.size(), 32'd0);
        chk("drain_dut2", q2.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
